vrf_wb_seq: RTL

- Vector writeback sequencer that sits directly upstream of the banked vector register file's write ports.
- Accepts one writeback command at a time: destination vreg, vl, SEW and mask mode.
- Then consumes result beats from the execution lanes. Each beat is BANK_COUNT words wide.
- Converts each beat into per-bank wrAddr/wrData/wrEn/wrBE, with tail and mask byte-enables, and signals completion.

---
 rtl/vrf_wb_seq_if.sv | 41 ++++
 rtl/vrf_wb_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_seq_if.sv
// Writeback sequencer bus: command, result beats and banked VRF write ports.
// The master drives commands and beats; the slave (sequencer) drives the write ports.
interface vrf_wb_seq_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int BANK_COUNT = 4,
    parameter int DATA_WIDTH = 32,
    parameter int VREG_WORDS = 8,
    parameter int VL_WIDTH   = 6
);
    localparam int VD_WIDTH   = ADDR_WIDTH - $clog2(VREG_WORDS);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int BEAT_BYTES = BANK_COUNT * BE_WIDTH;

    logic                                  cmd_valid;
    logic                                  cmd_ready;
    logic [VD_WIDTH-1:0]                   cmd_vd;
    logic [VL_WIDTH-1:0]                   cmd_vl;
    logic [1:0]                            cmd_sew;
    logic                                  cmd_vm;
    logic                                  res_valid;
    logic                                  res_ready;
    logic [BANK_COUNT*DATA_WIDTH-1:0]      res_data;
    logic [BEAT_BYTES-1:0]                 res_mask;
    logic [BANK_COUNT-1:0][ADDR_WIDTH-1:0] wrAddr;
    logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] wrData;
    logic [BANK_COUNT-1:0]                 wrEn;
    logic [BANK_COUNT-1:0][BE_WIDTH-1:0]   wrBE;
    logic                                  done;

    modport master (
        output cmd_valid, cmd_vd, cmd_vl, cmd_sew, cmd_vm,
        output res_valid, res_data, res_mask,
        input  cmd_ready, res_ready, wrAddr, wrData, wrEn, wrBE, done
    );

    modport slave (
        input  cmd_valid, cmd_vd, cmd_vl, cmd_sew, cmd_vm,
        input  res_valid, res_data, res_mask,
        output cmd_ready, res_ready, wrAddr, wrData, wrEn, wrBE, done
    );
endinterface

// File: rtl/vrf_wb_seq.sv
// Vector writeback sequencer: turns one command plus its result beats into
// per-bank VRF writes with tail/mask byte enables and a completion pulse.
module vrf_wb_seq #(
    parameter int ADDR_WIDTH      = 7,
    parameter int BANK_COUNT      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int VREG_WORDS      = 8,
    parameter int VL_WIDTH        = 6,
    parameter int ENABLE_STALLING = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    vrf_wb_seq_if.slave bus
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BEAT_BYTES     = BANK_COUNT * BYTES_PER_WORD;
    localparam int BEAT_SHIFT     = $clog2(BEAT_BYTES);
    localparam int BANK_SHIFT     = $clog2(BANK_COUNT);
    localparam int VREG_SHIFT     = $clog2(VREG_WORDS);
    localparam int TB_WIDTH       = VL_WIDTH + 2;
    localparam int NB_WIDTH       = TB_WIDTH + 1;
    localparam bit STALL_EN       = (ENABLE_STALLING != 0);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_next;

    logic [1:0]            sew_eff;
    logic [TB_WIDTH-1:0]   total_in;
    logic [TB_WIDTH-1:0]   nbeats_in;
    logic [TB_WIDTH-1:0]   total_q;
    logic [TB_WIDTH-1:0]   nbeats_q;
    logic [TB_WIDTH-1:0]   beat_q;
    logic [1:0]            sew_q;
    logic                  vm_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  cmd_ready_c;
    logic                  res_ready_c;
    logic                  accept;
    logic                  consume;
    logic                  last_beat;
    logic                  done_q;

    logic [TB_WIDTH-1:0]                   remain;
    logic [BEAT_BYTES-1:0]                 be_flat;
    logic [BANK_COUNT-1:0][ADDR_WIDTH-1:0] addr_next;

    logic [BANK_COUNT-1:0][ADDR_WIDTH-1:0]     wr_addr_q;
    logic [BANK_COUNT-1:0][DATA_WIDTH-1:0]     wr_data_q;
    logic [BANK_COUNT-1:0]                     wr_en_q;
    logic [BANK_COUNT-1:0][BYTES_PER_WORD-1:0] wr_be_q;

    // Reserved SEW encoding behaves as 32-bit elements.
    always_comb begin
        sew_eff   = (bus.cmd_sew == 2'd3) ? 2'd2 : bus.cmd_sew;
        total_in  = TB_WIDTH'(bus.cmd_vl) << sew_eff;
        nbeats_in = TB_WIDTH'((NB_WIDTH'(total_in) + NB_WIDTH'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
    end

    assign accept    = bus.cmd_valid && cmd_ready_c;
    assign consume   = bus.res_valid && res_ready_c;
    assign last_beat = (beat_q == nbeats_q - TB_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready_c = 1'b0;
        res_ready_c = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (accept) begin
                    state_next = (nbeats_in == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                res_ready_c = !(STALL_EN && stall);
                if (consume && last_beat) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q  <= '0;
            nbeats_q <= '0;
            beat_q   <= '0;
            sew_q    <= '0;
            vm_q     <= 1'b0;
            base_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FIN);
            if (accept) begin
                total_q  <= total_in;
                nbeats_q <= nbeats_in;
                beat_q   <= '0;
                sew_q    <= sew_eff;
                vm_q     <= bus.cmd_vm;
                base_q   <= {bus.cmd_vd, {VREG_SHIFT{1'b0}}};
            end else if (consume) begin
                beat_q <= beat_q + TB_WIDTH'(1);
            end
        end
    end

    // Byte j of the beat is live if it lies inside vl and its element is unmasked.
    always_comb begin
        remain  = total_q - (beat_q << BEAT_SHIFT);
        be_flat = '0;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            be_flat[j] = (TB_WIDTH'(j) < remain) && (vm_q || bus.res_mask[j >> sew_q]);
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            addr_next[b] = base_q + (ADDR_WIDTH'(beat_q) << BANK_SHIFT) + ADDR_WIDTH'(b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
            wr_be_q   <= '0;
        end else if (consume) begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                wr_addr_q[b] <= addr_next[b];
                wr_data_q[b] <= bus.res_data[b*DATA_WIDTH +: DATA_WIDTH];
                wr_be_q[b]   <= be_flat[b*BYTES_PER_WORD +: BYTES_PER_WORD];
                wr_en_q[b]   <= |be_flat[b*BYTES_PER_WORD +: BYTES_PER_WORD];
            end
        end else begin
            wr_en_q <= '0;
            wr_be_q <= '0;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.res_ready = res_ready_c;
    assign bus.wrAddr    = wr_addr_q;
    assign bus.wrData    = wr_data_q;
    assign bus.wrEn      = wr_en_q;
    assign bus.wrBE      = wr_be_q;
    assign bus.done      = done_q;
endmodule
